// File: rtl/mem_dma_if.sv
// Request/status and memory-bus bundle for mem_dma.
// Defining MEM_DMA_FILL_EN adds the fill and fill_data request fields.
interface mem_dma_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
`ifdef MEM_DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_data;
`endif
    logic             busy;
    logic             done;
    logic             error;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      address;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

`ifdef MEM_DMA_FILL_EN
    modport master (
        input  start, src_addr, dst_addr, word_count, fill, fill_data, mem_rdata,
        output busy, done, error, mem_read, mem_write, address, mem_wdata
    );
    modport slave (
        output start, src_addr, dst_addr, word_count, fill, fill_data, mem_rdata,
        input  busy, done, error, mem_read, mem_write, address, mem_wdata
    );
`else
    modport master (
        input  start, src_addr, dst_addr, word_count, mem_rdata,
        output busy, done, error, mem_read, mem_write, address, mem_wdata
    );
    modport slave (
        output start, src_addr, dst_addr, word_count, mem_rdata,
        input  busy, done, error, mem_read, mem_write, address, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_dma.sv
// Word-copy DMA engine: one read then one write per word over the data-memory bus.
// Optional MEM_DMA_FILL_EN adds a write-only fill mode (fill / fill_data).
module mem_dma #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    mem_dma_if.master bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

    localparam logic [31:0] Step = 32'(ADDR_STEP);

    state_e           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fill;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [31:0]      r_address;
    logic [31:0]      r_mem_wdata;

    logic             w_fill;
    logic [31:0]      w_fill_data;
    logic             w_misaligned;

`ifdef MEM_DMA_FILL_EN
    assign w_fill       = bus.fill;
    assign w_fill_data  = bus.fill_data;
    // Fill never reads, so the source alignment is irrelevant there.
    assign w_misaligned = (bus.dst_addr[1:0] != 2'b00) ||
                          (!bus.fill && (bus.src_addr[1:0] != 2'b00));
`else
    assign w_fill       = 1'b0;
    assign w_fill_data  = 32'h0;
    assign w_misaligned = (bus.dst_addr[1:0] != 2'b00) || (bus.src_addr[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_cnt       <= '0;
            r_fill      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_address   <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                        end else if (bus.word_count == '0) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_src  <= bus.src_addr;
                            r_dst  <= bus.dst_addr;
                            r_cnt  <= bus.word_count;
                            r_fill <= w_fill;
                            r_busy <= 1'b1;
                            if (w_fill) begin
                                r_state     <= StWrite;
                                r_mem_write <= 1'b1;
                                r_address   <= bus.dst_addr;
                                r_mem_wdata <= w_fill_data;
                            end else begin
                                r_state    <= StRead;
                                r_mem_read <= 1'b1;
                                r_address  <= bus.src_addr;
                            end
                        end
                    end
                end
                StRead: begin
                    r_mem_wdata <= bus.mem_rdata;
                    r_src       <= r_src + Step;
                    r_state     <= StWrite;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b1;
                    r_address   <= r_dst;
                end
                StWrite: begin
                    r_dst <= r_dst + Step;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= StFin;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_address   <= 32'h0;
                    end else if (r_fill) begin
                        r_address <= r_dst + Step;
                    end else begin
                        r_state     <= StRead;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_address   <= r_src;
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.address   = r_address;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: 64-word memory, randomized copies against a copy model.
// Fill-mode test is compiled in when MEM_DMA_FILL_EN is defined.
module tb_mem_dma;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mem_dma_if #(.CNT_W(CNT_W)) bus ();

    mem_dma #(.CNT_W(CNT_W), .ADDR_STEP(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory: combinational read, write at posedge, bulk load from the bench.
    logic        load_req = 1'b0;
    logic [31:0] load_img [64];
    logic [31:0] mem      [64];
    logic [31:0] exp_mem  [64];
    logic [32:0] exp_log  [$];

    assign bus.mem_rdata = mem[bus.address[7:2]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= load_img[i];
        end else if (bus.mem_write) begin
            mem[bus.address[7:2]] <= bus.mem_wdata;
        end
    end

    // Monitor: per-cycle counts and a log of {is_write, address} per strobe.
    logic        mon_clr = 1'b0;
    int          busy_cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [32:0] log_q [$];

    always @(negedge clk) begin
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_cnt <= both_cnt + 1;
        if (mon_clr) begin
            busy_cyc <= 0;
            done_cnt <= 0;
            err_cnt  <= 0;
            log_q.delete();
        end else begin
            if (bus.busy === 1'b1)      busy_cyc <= busy_cyc + 1;
            if (bus.done === 1'b1)      done_cnt <= done_cnt + 1;
            if (bus.error === 1'b1)     err_cnt  <= err_cnt + 1;
            if (bus.mem_read === 1'b1)  log_q.push_back({1'b0, bus.address});
            if (bus.mem_write === 1'b1) log_q.push_back({1'b1, bus.address});
        end
    end

    // Reference model: sequential word copy / fill over a 64-word address window.
    function automatic void model_copy(logic [31:0] s, logic [31:0] d, int n);
        logic [31:0] a_s, a_d;
        for (int i = 0; i < n; i++) begin
            a_s = s + 32'(4 * i);
            a_d = d + 32'(4 * i);
            exp_mem[a_d[7:2]] = exp_mem[a_s[7:2]];
            exp_log.push_back({1'b0, a_s});
            exp_log.push_back({1'b1, a_d});
        end
    endfunction

    function automatic void model_fill(logic [31:0] d, logic [31:0] v, int n);
        logic [31:0] a_d;
        for (int i = 0; i < n; i++) begin
            a_d = d + 32'(4 * i);
            exp_mem[a_d[7:2]] = v;
            exp_log.push_back({1'b1, a_d});
        end
    endfunction

    function automatic bit log_ok();
        if (log_q.size() != exp_log.size()) return 1'b0;
        foreach (log_q[i]) if (log_q[i] !== exp_log[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mem_ok();
        foreach (mem[i]) if (mem[i] !== exp_mem[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < 64; i++) begin
            load_img[i] = rnd ? $urandom : 32'(i);
            exp_mem[i]  = load_img[i];
        end
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic clear_mon();
        exp_log.delete();
        @(posedge clk); #1;
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    // Returns one ns after the edge that samples start (cycle 1 of the transfer).
    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.src_addr   = s;
        bus.dst_addr   = d;
        bus.word_count = CNT_W'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.done, bus.error});
        end
        n_tests++;
        if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00", {bus.mem_read, bus.mem_write});
        end
        n_tests++;
        if (bus.address !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr %h wdata %h expected 0 0", bus.address, bus.mem_wdata);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_copy();
        int k;
        load_mem(1'b0);
        clear_mon();
        model_copy(32'h0, 32'h40, 4);
        kick(32'h0, 32'h40, 4);
        wait_done(k);
        settle();
        n_tests++;
        if (k !== 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d expected 9", k); end
        n_tests++;
        if (busy_cyc !== 8) begin
            n_fail++; $display("FAIL copy_busy_cycles: got %0d expected 8", busy_cyc);
        end
        n_tests++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL copy_done_count: got %0d expected 1", done_cnt); end
        n_tests++;
        if (!log_ok()) begin
            n_fail++; $display("FAIL copy_bus_log: got %0d entries expected %0d", log_q.size(), exp_log.size());
        end
        n_tests++;
        if (!mem_ok()) begin
            n_fail++; $display("FAIL copy_mem: mem[16..19]=%h %h %h %h expected 0 1 2 3",
                               mem[16], mem[17], mem[18], mem[19]);
        end
    endtask

    task automatic test_zero_count();
        int k;
        clear_mon();
        kick(32'h0, 32'h40, 0);
        wait_done(k);
        settle();
        n_tests++;
        if (k !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", k); end
        n_tests++;
        if (busy_cyc !== 0 || log_q.size() !== 0) begin
            n_fail++; $display("FAIL zero_activity: busy %0d strobes %0d expected 0 0", busy_cyc, log_q.size());
        end
        n_tests++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_unaligned();
        int err_k;
        clear_mon();
        kick(32'h2, 32'h40, 3);
        err_k = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.error === 1'b1 && err_k < 0) err_k = c;
        end
        settle();
        n_tests++;
        if (err_k !== 1 || err_cnt !== 1) begin
            n_fail++; $display("FAIL unaligned_src_error: cycle %0d count %0d expected 1 1", err_k, err_cnt);
        end
        n_tests++;
        if (log_q.size() !== 0 || busy_cyc !== 0 || done_cnt !== 0) begin
            n_fail++; $display("FAIL unaligned_src_quiet: strobes %0d busy %0d done %0d expected 0 0 0",
                               log_q.size(), busy_cyc, done_cnt);
        end
        n_tests++;
        if (!mem_ok()) begin n_fail++; $display("FAIL unaligned_mem: got modified expected unchanged"); end
        clear_mon();
        kick(32'h0, 32'h41, 2);
        settle();
        n_tests++;
        if (err_cnt !== 1 || log_q.size() !== 0) begin
            n_fail++; $display("FAIL unaligned_dst: errors %0d strobes %0d expected 1 0", err_cnt, log_q.size());
        end
    endtask

    task automatic test_reset_mid();
        load_mem(1'b1);
        clear_mon();
        model_copy(32'h0, 32'h40, 1);
        kick(32'h0, 32'h40, 4);
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.mem_write !== 1'b1 || bus.address !== 32'h44) begin
            n_fail++; $display("FAIL midrst_second_write: wr %b addr %h expected 1 00000044",
                               bus.mem_write, bus.address);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write} !== 5'b0 ||
            bus.address !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs: flags %b addr %h wdata %h expected all 0",
                               {bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write},
                               bus.address, bus.mem_wdata);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_mon();
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if (done_cnt !== 0 || log_q.size() !== 0) begin
            n_fail++; $display("FAIL midrst_after: done %0d strobes %0d expected 0 0", done_cnt, log_q.size());
        end
        n_tests++;
        if (!mem_ok()) begin
            n_fail++; $display("FAIL midrst_mem: mem[16]=%h mem[17]=%h expected %h %h",
                               mem[16], mem[17], exp_mem[16], exp_mem[17]);
        end
    endtask

    task automatic test_start_busy();
        int k;
        load_mem(1'b1);
        clear_mon();
        model_copy(32'h0, 32'h80, 3);
        kick(32'h0, 32'h80, 3);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.src_addr   = 32'h10;
        bus.dst_addr   = 32'hC0;
        bus.word_count = CNT_W'(5);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(k);
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (k < 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL busy_start_done: cycle %0d count %0d expected >0 1", k, done_cnt);
        end
        n_tests++;
        if (!log_ok() || !mem_ok()) begin
            n_fail++; $display("FAIL busy_start_copy: log %0d/%0d mem_ok %b expected match",
                               log_q.size(), exp_log.size(), mem_ok());
        end
        // A start landing on the FIN cycle must also be dropped.
        clear_mon();
        model_copy(32'h20, 32'h60, 1);
        kick(32'h20, 32'h60, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.src_addr   = 32'h30;
        bus.dst_addr   = 32'h70;
        bus.word_count = CNT_W'(2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (done_cnt !== 1 || !log_ok()) begin
            n_fail++; $display("FAIL fin_start: done %0d strobes %0d expected 1 %0d",
                               done_cnt, log_q.size(), exp_log.size());
        end
    endtask

    task automatic run_random_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                                   input int n);
        int k;
        clear_mon();
        model_copy(s, d, n);
        kick(s, d, n);
        wait_done(k);
        settle();
        n_tests++;
        if (k !== 2 * n + 1 || busy_cyc !== 2 * n) begin
            n_fail++; $display("FAIL %s_timing: done %0d busy %0d expected %0d %0d",
                               name, k, busy_cyc, 2 * n + 1, 2 * n);
        end
        n_tests++;
        if (!log_ok()) begin
            n_fail++; $display("FAIL %s_bus_log: got %0d entries expected %0d (src %h dst %h n %0d)",
                               name, log_q.size(), exp_log.size(), s, d, n);
        end
        n_tests++;
        if (!mem_ok()) begin
            n_fail++; $display("FAIL %s_mem: got mismatch expected copied block (src %h dst %h n %0d)",
                               name, s, d, n);
        end
    endtask

    task automatic test_random();
        load_mem(1'b1);
        for (int it = 0; it < 8; it++) begin
            run_random_copy("rand", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                            int'($urandom_range(1, 12)));
        end
    endtask

    task automatic test_wrap();
        load_mem(1'b1);
        run_random_copy("wrap", 32'hFFFF_FFF8, 32'h40, 3);
        n_tests++;
        if (err_cnt !== 0) begin n_fail++; $display("FAIL wrap_error: got %0d expected 0", err_cnt); end
    endtask

`ifdef MEM_DMA_FILL_EN
    task automatic test_fill();
        int k;
        load_mem(1'b1);
        clear_mon();
        model_fill(32'h20, 32'hDEAD_BEEF, 3);
        bus.fill      = 1'b1;
        bus.fill_data = 32'hDEAD_BEEF;
        kick(32'h3, 32'h20, 3);
        wait_done(k);
        settle();
        bus.fill = 1'b0;
        n_tests++;
        if (k !== 4 || busy_cyc !== 3) begin
            n_fail++; $display("FAIL fill_timing: done %0d busy %0d expected 4 3", k, busy_cyc);
        end
        n_tests++;
        if (!log_ok() || err_cnt !== 0) begin
            n_fail++; $display("FAIL fill_bus_log: entries %0d errors %0d expected %0d 0",
                               log_q.size(), err_cnt, exp_log.size());
        end
        n_tests++;
        if (!mem_ok()) begin
            n_fail++; $display("FAIL fill_mem: mem[8..10]=%h %h %h expected deadbeef",
                               mem[8], mem[9], mem[10]);
        end
    endtask
`endif

    initial begin
        bus.start      = 1'b0;
        bus.src_addr   = 32'h0;
        bus.dst_addr   = 32'h0;
        bus.word_count = '0;
`ifdef MEM_DMA_FILL_EN
        bus.fill      = 1'b0;
        bus.fill_data = 32'h0;
`endif
        test_reset();
        test_copy();
        test_zero_count();
        test_unaligned();
        test_reset_mid();
        test_start_busy();
        test_random();
        test_wrap();
`ifdef MEM_DMA_FILL_EN
        test_fill();
`endif
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
